// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg -- shared pipeline definitions for the fetch/hazard logic.
//   NOP_INSTR      : bubble encoding (add $0,$2,$1), never creates a hazard
//   OP_*           : primary opcodes the hazard logic decodes
//   fetch_state_e  : fetch-hold state machine encoding
//   instr_fields_t : decoded register usage of one instruction
package cpu_pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0041_0020;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BGTZ  = 6'h07;

  typedef enum logic [1:0] {
    RUN = 2'd0,
    BR1 = 2'd1,
    BR2 = 2'd2,
    BR3 = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [4:0] dest;
    logic       dest_vld;
    logic [4:0] rs;
    logic       rs_used;
    logic [4:0] rt;
    logic       rt_used;
    logic       is_branch;
  } instr_fields_t;

  // Immediate ALU group (addi .. lui) occupies opcodes 0x08-0x0F.
  function automatic logic is_imm_alu(input logic [5:0] op);
    return op[5:3] == 3'b001;
  endfunction

endpackage

// File: rtl/reg_field_decode.sv
// reg_field_decode -- purely combinational register-usage decode.
//   instr_i  : 32-bit instruction
//   fields_o : dest / dest_vld, rs / rs_used, rt / rt_used, is_branch
// $0 is never reported as a used source or a valid destination, so
// downstream compare logic needs no special zero-register case.
module reg_field_decode
  import cpu_pipe_pkg::*;
(
  input  logic [31:0]   instr_i,
  output instr_fields_t fields_o
);

  logic [5:0] op;
  logic [4:0] rs, rt, rd;
  logic       unused_lsbs;

  assign op = instr_i[31:26];
  assign rs = instr_i[25:21];
  assign rt = instr_i[20:16];
  assign rd = instr_i[15:11];

  // shamt/funct/immediate bits carry no register information.
  assign unused_lsbs = ^instr_i[10:0];

  always_comb begin
    fields_o      = '0;
    fields_o.rs   = rs;
    fields_o.rt   = rt;

    if (op == OP_RTYPE) begin
      fields_o.dest     = rd;
      fields_o.dest_vld = 1'b1;
    end else if (op == OP_LW || is_imm_alu(op)) begin
      fields_o.dest     = rt;
      fields_o.dest_vld = 1'b1;
    end
    if (fields_o.dest == 5'd0) fields_o.dest_vld = 1'b0;

    fields_o.rs_used = (rs != 5'd0);
    fields_o.rt_used = (rt != 5'd0) &&
                       (op == OP_RTYPE || op == OP_SW || op == OP_BEQ || op == OP_BNE);

    fields_o.is_branch = (op == OP_BEQ || op == OP_BNE || op == OP_BGTZ);
  end

endmodule

// File: rtl/fetch_hazard_unit.sv
// fetch_hazard_unit -- fetch-stage RAW interlock and branch hold.
//   clk, rst            : clock, synchronous active-high reset
//   if_instr/if_pc      : fetched instruction and its address
//   if_pc_plus4         : sequential next PC from the fetch unit
//   br_taken/br_target  : MEM-stage branch outcome, consumed only in BR3
//   out_instr           : instruction to IF/ID (if_instr or NOP_INSTR)
//   out_pc              : next value of the PC register
//   stall               : a bubble is issued this cycle
//   stall_cnt/squash_cnt: saturating statistics, present only when the
//                         macro FETCH_HAZARD_STATS_EN is defined
// All outputs are combinational from state, history and inputs.
module fetch_hazard_unit
  import cpu_pipe_pkg::*;
#(
  parameter int HIST_DEPTH = 3,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_pc_plus4,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        stall
`ifdef FETCH_HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] squash_cnt
`endif
);

  fetch_state_e                   state_q, state_d;
  instr_fields_t                  fields;
  logic [HIST_DEPTH-1:0]          hist_vld_q;
  logic [HIST_DEPTH-1:0][4:0]     hist_dest_q;
  logic [HIST_DEPTH-1:0]          hit;
  logic                           hazard;
  logic                           push_vld;

  reg_field_decode u_decode (
    .instr_i  (if_instr),
    .fields_o (fields)
  );

  // One comparator pair per in-flight producer; entry 0 is the youngest.
  for (genvar i = 0; i < HIST_DEPTH; i++) begin : g_hist_cmp
    assign hit[i] = hist_vld_q[i] &&
                    ((fields.rs_used && fields.rs == hist_dest_q[i]) ||
                     (fields.rt_used && fields.rt == hist_dest_q[i]));
  end
  assign hazard = |hit;

  always_comb begin
    state_d   = state_q;
    out_instr = NOP_INSTR;
    out_pc    = if_pc;
    stall     = 1'b1;
    push_vld  = 1'b0;

    if (rst) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          // Hazard wins over branch detection: a hazarded branch just waits.
          if (!hazard) begin
            out_instr = if_instr;
            out_pc    = if_pc_plus4;
            stall     = 1'b0;
            push_vld  = fields.dest_vld;
            if (fields.is_branch) state_d = BR1;
          end
        end
        BR1: state_d = BR2;
        BR2: state_d = BR3;
        BR3: begin
          if (br_taken) out_pc = br_target;
          state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Bubbles and branches shift in valid=0 so producers age out on schedule.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_vld_q <= '0;
    end else begin
      for (int i = HIST_DEPTH - 1; i > 0; i--) hist_vld_q[i] <= hist_vld_q[i-1];
      hist_vld_q[0] <= push_vld;
    end
  end

  // Destination tags are only meaningful under their valid bit; no reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = HIST_DEPTH - 1; i > 0; i--) hist_dest_q[i] <= hist_dest_q[i-1];
      hist_dest_q[0] <= fields.dest;
    end
  end

`ifdef FETCH_HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, squash_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      if (state_q == RUN && hazard && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (state_q != RUN && squash_cnt_q != '1)
        squash_cnt_q <= squash_cnt_q + 1'b1;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign squash_cnt = squash_cnt_q;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_fetch_hazard_unit.sv
// tb_fetch_hazard_unit -- directed, self-checking bench for fetch_hazard_unit.
// Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
module tb_fetch_hazard_unit;
  import cpu_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_instr, if_pc, if_pc_plus4, br_target;
  logic        br_taken;
  logic [31:0] out_instr, out_pc;
  logic        stall;
`ifdef FETCH_HAZARD_STATS_EN
  logic [15:0] stall_cnt, squash_cnt;
`endif

  int tests = 0;
  int fails = 0;

  fetch_hazard_unit #(.HIST_DEPTH(3), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus4 (if_pc_plus4),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .stall       (stall)
`ifdef FETCH_HAZARD_STATS_EN
    ,
    .stall_cnt   (stall_cnt),
    .squash_cnt  (squash_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    if_instr    = instr;
    if_pc       = pc;
    if_pc_plus4 = pc + 32'd4;
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; br_taken = 1'b0; br_target = 32'h0;
    drive(NOP_INSTR, 32'h0);
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; br_taken = 1'b1; br_target = 32'hAAAA_0000;
    for (int c = 0; c < 2; c++) begin
      drive(32'hDEAD_BEEF + c, 32'h100 + 32'(c) * 4);
      tests++;
      if ({out_instr, out_pc, stall} !== {32'h0041_0020, 32'h100 + 32'(c) * 4, 1'b1}) begin
        fails++;
        $display("FAIL reset_hold%0d: instr/pc/stall got %h/%h/%b want 00410020/%h/1",
                 c, out_instr, out_pc, stall, 32'h100 + 32'(c) * 4);
      end
      next_cycle();
    end
    rst = 1'b0; br_taken = 1'b0;
    // add $1,$1,$1 would hazard on any stale producer of $1
    drive(rtype(5'd1, 5'd1, 5'd1, 6'h20), 32'h200);
    tests++;
    if ({out_instr, out_pc, stall} !== {rtype(5'd1, 5'd1, 5'd1, 6'h20), 32'h204, 1'b0}) begin
      fails++;
      $display("FAIL reset_release: instr/pc/stall got %h/%h/%b want %h/00000204/0",
               out_instr, out_pc, stall, rtype(5'd1, 5'd1, 5'd1, 6'h20));
    end
    next_cycle();
`ifdef FETCH_HAZARD_STATS_EN
    drive(NOP_INSTR, 32'h204);
    tests++;
    if ({stall_cnt, squash_cnt} !== 32'h0) begin
      fails++;
      $display("FAIL reset_counters: got %h/%h want 0/0", stall_cnt, squash_cnt);
    end
`endif
  endtask

  task automatic test_raw();
    logic [31:0] sub_i;
    sub_i = rtype(5'd3, 5'd5, 5'd4, 6'h22);
    do_reset();
    drive(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'h0);
    tests++;
    if (stall !== 1'b0) begin
      fails++; $display("FAIL raw_producer: stall got %b want 0", stall);
    end
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      drive(sub_i, 32'h4);
      tests++;
      if ({out_instr, out_pc, stall} !== {32'h0041_0020, 32'h4, 1'b1}) begin
        fails++;
        $display("FAIL raw_bubble%0d: instr/pc/stall got %h/%h/%b want 00410020/00000004/1",
                 c, out_instr, out_pc, stall);
      end
      next_cycle();
    end
    drive(sub_i, 32'h4);
    tests++;
    if ({out_instr, out_pc, stall} !== {sub_i, 32'h8, 1'b0}) begin
      fails++;
      $display("FAIL raw_issue: instr/pc/stall got %h/%h/%b want %h/00000008/0",
               out_instr, out_pc, stall, sub_i);
    end
`ifdef FETCH_HAZARD_STATS_EN
    tests++;
    if (stall_cnt !== 16'd3) begin
      fails++; $display("FAIL raw_stall_cnt: got %0d want 3", stall_cnt);
    end
`endif
    next_cycle();
  endtask

  task automatic test_zero_reg();
    do_reset();
    drive(rtype(5'd1, 5'd2, 5'd0, 6'h20), 32'h10);
    next_cycle();
    drive(rtype(5'd0, 5'd0, 5'd5, 6'h20), 32'h14);
    tests++;
    if ({out_instr, stall} !== {rtype(5'd0, 5'd0, 5'd5, 6'h20), 1'b0}) begin
      fails++;
      $display("FAIL zero_reg: instr/stall got %h/%b want %h/0",
               out_instr, stall, rtype(5'd0, 5'd0, 5'd5, 6'h20));
    end
    next_cycle();
  endtask

  task automatic test_decode();
    // lw writes rt: dependent add must stall
    do_reset();
    drive(itype(OP_LW, 5'd1, 5'd7, 16'h0), 32'h20);
    next_cycle();
    drive(rtype(5'd7, 5'd0, 5'd8, 6'h20), 32'h24);
    tests++;
    if (stall !== 1'b1) begin
      fails++; $display("FAIL lw_dest: stall got %b want 1", stall);
    end
    // sw writes nothing: reader of its rt does not stall
    do_reset();
    drive(itype(OP_SW, 5'd1, 5'd9, 16'h0), 32'h30);
    next_cycle();
    drive(rtype(5'd9, 5'd0, 5'd10, 6'h20), 32'h34);
    tests++;
    if (stall !== 1'b0) begin
      fails++; $display("FAIL sw_nodest: stall got %b want 0", stall);
    end
    // addi writes rt, consumer reads it through rt of an R-type
    do_reset();
    drive(itype(6'h08, 5'd1, 5'd11, 16'h5), 32'h40);
    next_cycle();
    drive(rtype(5'd0, 5'd11, 5'd12, 6'h20), 32'h44);
    tests++;
    if (stall !== 1'b1) begin
      fails++; $display("FAIL addi_dest_rt_src: stall got %b want 1", stall);
    end
    next_cycle();
  endtask

  task automatic run_branch(input logic taken, input string tag);
    logic [31:0] beq_i, add_i;
    beq_i = itype(OP_BEQ, 5'd1, 5'd2, 16'h000F);
    add_i = rtype(5'd1, 5'd2, 5'd6, 6'h20);
    do_reset();
    br_target = 32'h80;
    drive(beq_i, 32'h40);
    tests++;
    if ({out_instr, out_pc, stall} !== {beq_i, 32'h44, 1'b0}) begin
      fails++;
      $display("FAIL %s_issue: instr/pc/stall got %h/%h/%b want %h/00000044/0",
               tag, out_instr, out_pc, stall, beq_i);
    end
    next_cycle();
    for (int c = 1; c <= 3; c++) begin
      // BR1 sees a spurious br_taken pulse; only BR3 may use it
      br_taken = (c == 1) ? 1'b1 : ((c == 3) ? taken : 1'b0);
      drive((c == 2) ? beq_i : add_i, 32'h44);
      tests++;
      if ({out_instr, out_pc, stall} !==
          {32'h0041_0020, ((c == 3 && taken) ? 32'h80 : 32'h44), 1'b1}) begin
        fails++;
        $display("FAIL %s_br%0d: instr/pc/stall got %h/%h/%b want 00410020/%h/1",
                 tag, c, out_instr, out_pc, stall, (c == 3 && taken) ? 32'h80 : 32'h44);
      end
      next_cycle();
    end
    br_taken = 1'b0;
    drive(add_i, taken ? 32'h80 : 32'h44);
    tests++;
    if ({out_instr, out_pc, stall} !== {add_i, (taken ? 32'h84 : 32'h48), 1'b0}) begin
      fails++;
      $display("FAIL %s_resume: instr/pc/stall got %h/%h/%b want %h/%h/0",
               tag, out_instr, out_pc, stall, add_i, taken ? 32'h84 : 32'h48);
    end
`ifdef FETCH_HAZARD_STATS_EN
    tests++;
    if (squash_cnt !== 16'd3) begin
      fails++; $display("FAIL %s_squash_cnt: got %0d want 3", tag, squash_cnt);
    end
`endif
    next_cycle();
  endtask

  task automatic test_taken_branch();
    run_branch(1'b1, "taken");
  endtask

  task automatic test_not_taken_branch();
    run_branch(1'b0, "ntaken");
  endtask

  task automatic test_hazard_branch();
    logic [31:0] beq_i;
    beq_i = itype(OP_BNE, 5'd1, 5'd2, 16'h4);
    do_reset();
    drive(rtype(5'd2, 5'd3, 5'd1, 6'h20), 32'h60);
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      drive(beq_i, 32'h64);
      tests++;
      if ({out_instr, stall} !== {32'h0041_0020, 1'b1}) begin
        fails++;
        $display("FAIL hzbr_bubble%0d: instr/stall got %h/%b want 00410020/1", c, out_instr, stall);
      end
      next_cycle();
    end
    drive(beq_i, 32'h64);
    tests++;
    if ({out_instr, out_pc, stall} !== {beq_i, 32'h68, 1'b0}) begin
      fails++;
      $display("FAIL hzbr_issue: instr/pc/stall got %h/%h/%b want %h/00000068/0",
               out_instr, out_pc, stall, beq_i);
    end
    next_cycle();
    drive(rtype(5'd7, 5'd8, 5'd9, 6'h20), 32'h68);
    tests++;
    if (stall !== 1'b1) begin
      fails++; $display("FAIL hzbr_br1: stall got %b want 1", stall);
    end
    next_cycle();
  endtask

  task automatic test_mid_branch_reset();
    logic [31:0] add_i;
    add_i = rtype(5'd1, 5'd2, 5'd6, 6'h20);
    do_reset();
    br_target = 32'h80;
    drive(itype(OP_BEQ, 5'd1, 5'd2, 16'h000F), 32'h40);
    next_cycle();
    drive(add_i, 32'h44);  // BR1
    next_cycle();
    rst = 1'b1; br_taken = 1'b1;
    drive(add_i, 32'h44);  // BR2 under reset
    tests++;
    if ({out_instr, out_pc, stall} !== {32'h0041_0020, 32'h44, 1'b1}) begin
      fails++;
      $display("FAIL midrst_hold: instr/pc/stall got %h/%h/%b want 00410020/00000044/1",
               out_instr, out_pc, stall);
    end
    next_cycle();
    rst = 1'b0;
    drive(add_i, 32'h44);
    tests++;
    if ({out_instr, out_pc, stall} !== {add_i, 32'h48, 1'b0}) begin
      fails++;
      $display("FAIL midrst_run: instr/pc/stall got %h/%h/%b want %h/00000048/0",
               out_instr, out_pc, stall, add_i);
    end
`ifdef FETCH_HAZARD_STATS_EN
    tests++;
    if (squash_cnt !== 16'd0) begin
      fails++; $display("FAIL midrst_squash_cnt: got %0d want 0", squash_cnt);
    end
`endif
    br_taken = 1'b0;
    next_cycle();
  endtask

  initial begin
    rst = 1'b1; br_taken = 1'b0; br_target = 32'h0;
    if_instr = 32'h0; if_pc = 32'h0; if_pc_plus4 = 32'h4;
    next_cycle();
    test_reset();
    test_raw();
    test_zero_reg();
    test_decode();
    test_taken_branch();
    test_not_taken_branch();
    test_hazard_branch();
    test_mid_branch_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
